dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 16 +
 rtl/dmem_array.sv | 32 +++
 rtl/dmem_responder.sv | 142 ++++++++++++++
 tb/tb_dmem_responder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the fixed-latency data-memory responder: FSM encoding and default widths.
// No logic; imported by the control FSM and the storage datapath.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 16;
    // LATENCY tops out at 15, so a 4-bit down-counter always suffices.
    localparam int CNT_WIDTH      = 4;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage: synchronous write, registered read, no reset.
// One-cycle read latency; en qualifies both ports, no backpressure.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = 256,
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  mem_en,
    input  logic                  mem_we,
    input  logic [IDX_W-1:0]      mem_idx,
    input  logic [DATA_WIDTH-1:0] mem_wdat,
    output logic [DATA_WIDTH-1:0] mem_rdat
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdat_q;

    always_ff @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem_q[mem_idx] <= mem_wdat;
            end
            rdat_q <= mem_q[mem_idx];
        end
    end

    assign mem_rdat = rdat_q;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding memory responder answering each request after LATENCY cycles.
// req_ready drops from acceptance until the response cycle ends; next accept LATENCY+1 cycles later.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    localparam int                    IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_WIDTH-1:0]  CNT_LOAD  = CNT_WIDTH'(LATENCY - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic                  err_q, err_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                  accept;
    logic                  req_in_range;
    logic                  cur_write;
    logic                  cur_in_range;
    logic [IDX_W-1:0]      cur_idx;
    logic [DATA_WIDTH-1:0] cur_wdata;
    logic                  mem_en;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdat;

    assign accept       = req_valid && req_ready;
    assign req_in_range = {1'b0, req_addr} < DEPTH_EXT;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        write_q <= write_d;
        err_q   <= err_d;
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_d = ST_RESPOND;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_WIDTH'(1)) begin
                    state_d = ST_RESPOND;
                end
            end
            ST_RESPOND: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        write_d = write_q;
        err_d   = err_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        if (accept) begin
            write_d = req_write;
            err_d   = !req_in_range;
            idx_d   = req_addr[IDX_W-1:0];
            wdata_d = req_wdata;
        end
    end

    // With LATENCY==1 storage is touched on the accepting edge, so the live request bypasses the latches.
    always_comb begin
        cur_write    = write_q;
        cur_in_range = !err_q;
        cur_idx      = idx_q;
        cur_wdata    = wdata_q;
        if (state_q == ST_IDLE) begin
            cur_write    = req_write;
            cur_in_range = req_in_range;
            cur_idx      = req_addr[IDX_W-1:0];
            cur_wdata    = req_wdata;
        end
    end

    // Storage is accessed only on the edge entering RESPOND; reset there aborts an uncommitted write.
    assign mem_en = (state_d == ST_RESPOND) && !reset;
    assign mem_we = mem_en && cur_write && cur_in_range;

    dmem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk      (clk),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_idx  (cur_idx),
        .mem_wdat (cur_wdata),
        .mem_rdat (mem_rdat)
    );

    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        resp_valid = (state_q == ST_RESPOND);
        resp_err   = resp_valid && err_q;
        resp_rdata = '0;
        if (resp_valid && !write_q && !err_q) begin
            resp_rdata = mem_rdat;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 and LATENCY=1 instances, directed requests,
// a transaction-level reference model compared every cycle, plus literal expectations.
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic [1:0]  rv, rw;
    logic [15:0] ra [2];
    logic [31:0] wd [2];
    logic [1:0]  rdy, vld, er;
    logic [31:0] rdt [2];

    int n_cmp;
    int n_fail;
    bit chk_en;

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(256), .LATENCY(2)) dut0 (
        .clk(clk), .reset(rst), .req_valid(rv[0]), .req_write(rw[0]), .req_addr(ra[0]),
        .req_wdata(wd[0]), .req_ready(rdy[0]), .resp_valid(vld[0]), .resp_rdata(rdt[0]),
        .resp_err(er[0])
    );

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(256), .LATENCY(1)) dut1 (
        .clk(clk), .reset(rst), .req_valid(rv[1]), .req_write(rw[1]), .req_addr(ra[1]),
        .req_wdata(wd[1]), .req_ready(rdy[1]), .resp_valid(vld[1]), .resp_rdata(rdt[1]),
        .resp_err(er[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got timeout want response within 40 cycles", name);
    endtask

    // Reference model: phase counts cycles left until idle; the response shows while phase==1.
    logic        s_rst;
    logic [1:0]  s_rv, s_rw;
    logic [15:0] s_ra [2];
    logic [31:0] s_wd [2];

    always @(posedge clk) begin
        s_rst <= rst;
        s_rv  <= rv;
        s_rw  <= rw;
        s_ra  <= ra;
        s_wd  <= wd;
    end

    int          ph   [2];
    logic        m_wr [2];
    logic [15:0] m_a  [2];
    logic [31:0] m_d  [2];
    logic [31:0] m_rd [2];
    logic [31:0] mm   [2][256];

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    task automatic commit(input int i);
        m_rd[i] = 32'h0;
        if (m_a[i] < 16'd256) begin
            if (m_wr[i]) mm[i][m_a[i][7:0]] = m_d[i];
            else         m_rd[i] = mm[i][m_a[i][7:0]];
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            ph[i] = 0;
            for (int j = 0; j < 256; j++) mm[i][j] = 32'h0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (s_rst) begin
                    ph[i] = 0;
                end else if (ph[i] == 0) begin
                    if (s_rv[i]) begin
                        m_wr[i] = s_rw[i];
                        m_a[i]  = s_ra[i];
                        m_d[i]  = s_wd[i];
                        ph[i]   = lat_of(i);
                        if (ph[i] == 1) commit(i);
                    end
                end else begin
                    ph[i] = ph[i] - 1;
                    if (ph[i] == 1) commit(i);
                end
                if (chk_en) begin
                    logic        e_vld, e_err;
                    logic [31:0] e_rd;
                    e_vld = (ph[i] == 1);
                    e_err = e_vld && (m_a[i] >= 16'd256);
                    e_rd  = (e_vld && !m_wr[i] && !e_err) ? m_rd[i] : 32'h0;
                    chk($sformatf("u%0d req_ready", i),  {31'b0, rdy[i]}, {31'b0, ph[i] == 0});
                    chk($sformatf("u%0d resp_valid", i), {31'b0, vld[i]}, {31'b0, e_vld});
                    chk($sformatf("u%0d resp_err", i),   {31'b0, er[i]},  {31'b0, e_err});
                    chk($sformatf("u%0d resp_rdata", i), rdt[i], e_rd);
                end
            end
        end
    end

    task automatic do_req(input int i, input logic w, input logic [15:0] a, input logic [31:0] d,
                          output logic [31:0] rdat, output logic err, output int lat);
        int n;
        rdat = 32'h0;
        err  = 1'b0;
        @(negedge clk);
        rv[i] = 1'b1; rw[i] = w; ra[i] = a; wd[i] = d;
        n = 0;
        while (!rdy[i] && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) timeout_fail("accept wait");
        @(negedge clk);
        rv[i] = 1'b0;
        lat = 1;
        n = 0;
        while (!vld[i] && n < 40) begin @(negedge clk); lat++; n++; end
        if (n >= 40) timeout_fail("response wait");
        rdat = rdt[i];
        err  = er[i];
    endtask

    task automatic hold(input int i, input int ncyc, input logic [15:0] a,
                        output int acc, output int gap);
        int last;
        last = -1; acc = 0; gap = 0;
        @(negedge clk);
        rv[i] = 1'b1; rw[i] = 1'b0; ra[i] = a;
        for (int k = 0; k < ncyc; k++) begin
            if (rdy[i]) begin
                if (last >= 0) gap = k - last;
                last = k;
                acc++;
            end
            @(negedge clk);
        end
        rv[i] = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat, acc, gap, cnt;
        n_cmp = 0; n_fail = 0; chk_en = 1'b0;
        rst = 1'b1; rv = '0; rw = '0;
        for (int i = 0; i < 2; i++) begin ra[i] = '0; wd[i] = '0; end
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        rst = 1'b0;
        chk("reset ready0", {31'b0, rdy[0]}, 32'd1);
        chk("reset valid0", {31'b0, vld[0]}, 32'd0);
        chk("reset err0",   {31'b0, er[0]},  32'd0);
        chk("reset ready1", {31'b0, rdy[1]}, 32'd1);

        do_req(0, 1'b1, 16'h0005, 32'hDEADBEEF, rd, e, lat);
        chk("wr5 latency", 32'(lat), 32'd2);
        chk("wr5 err", {31'b0, e}, 32'd0);
        chk("wr5 rdata", rd, 32'h0);
        do_req(0, 1'b0, 16'h0005, 32'h0, rd, e, lat);
        chk("rd5 data", rd, 32'hDEADBEEF);
        chk("rd5 latency", 32'(lat), 32'd2);

        hold(0, 9, 16'h0005, acc, gap);
        chk("l2 accepts", 32'(acc), 32'd3);
        chk("l2 spacing", 32'(gap), 32'd3);
        repeat (4) @(negedge clk);

        do_req(0, 1'b1, 16'h0000, 32'h0A0B0C0D, rd, e, lat);
        do_req(0, 1'b1, 16'h0100, 32'hFFFFFFFF, rd, e, lat);
        chk("wr100 err", {31'b0, e}, 32'd1);
        chk("wr100 rdata", rd, 32'h0);
        do_req(0, 1'b0, 16'h0000, 32'h0, rd, e, lat);
        chk("rd0 data", rd, 32'h0A0B0C0D);
        chk("rd0 err", {31'b0, e}, 32'd0);
        do_req(0, 1'b0, 16'h0123, 32'h0, rd, e, lat);
        chk("rd123 err", {31'b0, e}, 32'd1);
        chk("rd123 rdata", rd, 32'h0);

        // Reset lands in WAIT: the pending write must vanish.
        do_req(0, 1'b1, 16'h0007, 32'h11112222, rd, e, lat);
        @(negedge clk);
        rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 16'h0007; wd[0] = 32'h12345678;
        chk("abort ready", {31'b0, rdy[0]}, 32'd1);
        @(negedge clk);
        rv[0] = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (4) begin if (vld[0]) cnt++; @(negedge clk); end
        chk("abort no resp", 32'(cnt), 32'd0);
        do_req(0, 1'b0, 16'h0007, 32'h0, rd, e, lat);
        chk("rd7 old data", rd, 32'h11112222);

        // Request presented alongside reset is dropped.
        do_req(0, 1'b1, 16'h0009, 32'h00000099, rd, e, lat);
        @(negedge clk);
        rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 16'h0009; wd[0] = 32'h00000BAD; rst = 1'b1;
        @(negedge clk);
        rv[0] = 1'b0; rst = 1'b0;
        chk("rst+valid ready", {31'b0, rdy[0]}, 32'd1);
        cnt = 0;
        repeat (3) begin if (vld[0]) cnt++; @(negedge clk); end
        chk("rst+valid no resp", 32'(cnt), 32'd0);
        do_req(0, 1'b0, 16'h0009, 32'h0, rd, e, lat);
        chk("rd9 data", rd, 32'h00000099);

        do_req(1, 1'b1, 16'h0003, 32'hCAFEF00D, rd, e, lat);
        chk("l1 wr latency", 32'(lat), 32'd1);
        do_req(1, 1'b0, 16'h0003, 32'h0, rd, e, lat);
        chk("l1 rd data", rd, 32'hCAFEF00D);
        chk("l1 rd latency", 32'(lat), 32'd1);
        hold(1, 8, 16'h0003, acc, gap);
        chk("l1 accepts", 32'(acc), 32'd4);
        chk("l1 spacing", 32'(gap), 32'd2);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
